// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x64 register bank.
// Sweeps X0..X30 after reset, then shares we3/wa3/wd3 between two requesters.
module regfile_write_arbiter #(
    parameter bit          INIT_EN      = 1'b1,
    parameter logic [63:0] INIT_VALUE   = 64'd0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [4:0]  r0_addr,
    input  logic [63:0] r0_data,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [4:0]  r1_addr,
    input  logic [63:0] r1_data,
    output logic        init_busy,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [63:0] wd3
);

    localparam logic [0:0] S_INIT    = 1'b0;
    localparam logic [0:0] S_RUN     = 1'b1;
    localparam logic [0:0] S_RST     = INIT_EN ? S_INIT : S_RUN;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [4:0] XZR       = 5'd31;
    localparam logic [4:0] LAST_INIT = 5'd30;

    logic [0:0]  state_q, state_d;
    logic [4:0]  init_cnt_q, init_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        we3_q, we3_d;
    logic [4:0]  wa3_q, wa3_d;
    logic [63:0] wd3_q, wd3_d;

    logic in_run;
    logic force1;
    logic r0_fire;
    logic r1_fire;

    // Handshake: r0 has priority unless r1 has been starved too long
    always_comb begin
        in_run   = (state_q == S_RUN) & ~reset;
        force1   = (starve_cnt_q == LIMIT) & r1_valid;
        r0_ready = in_run & ~force1;
        r1_ready = in_run & (force1 | ~r0_valid);
        r0_fire  = r0_valid & r0_ready;
        r1_fire  = r1_valid & r1_ready;
    end

    assign init_busy = (state_q == S_INIT);
    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;

    // Next-state: init sweep, grant selection and starvation counting
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        unique case (state_q)
            S_INIT: begin
                we3_d      = 1'b1;
                wa3_d      = init_cnt_q;
                wd3_d      = INIT_VALUE;
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == LAST_INIT) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (r0_fire) begin
                    wa3_d = r0_addr;
                    wd3_d = r0_data;
                    we3_d = (r0_addr != XZR);
                end else if (r1_fire) begin
                    wa3_d = r1_addr;
                    wd3_d = r1_data;
                    we3_d = (r1_addr != XZR);
                end
                if (r1_fire || !r1_valid) begin
                    starve_cnt_d = 4'd0;
                end else if (r0_fire && (starve_cnt_q < LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
        endcase
    end

    // State and registered write-port outputs; reset drops any in-flight write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RST;
            init_cnt_q   <= 5'd0;
            starve_cnt_q <= 4'd0;
            we3_q        <= 1'b0;
            wa3_q        <= 5'd0;
            wd3_q        <= 64'd0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// INIT_VALUE=DEAD, STARVE_LIMIT=3.
module tb_regfile_write_arbiter;

    localparam logic [63:0] IV = 64'hDEAD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0;
    logic        r0_ready;
    logic [4:0]  r0_addr = 5'd0;
    logic [63:0] r0_data = 64'd0;
    logic        r1_valid = 1'b0;
    logic        r1_ready;
    logic [4:0]  r1_addr = 5'd0;
    logic [63:0] r1_data = 64'd0;
    logic        init_busy;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;

    int n_chk = 0;
    int n_err = 0;

    regfile_write_arbiter #(
        .INIT_EN      (1'b1),
        .INIT_VALUE   (IV),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_addr   (r0_addr),
        .r0_data   (r0_data),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_addr   (r1_addr),
        .r1_data   (r1_data),
        .init_busy (init_busy),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g;
        logic [7:0] seq8;
        logic [3:0] seq4;

        // reset state
        step();
        step();
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", wd3, 64'd0);
        chk("rst_busy", 64'(init_busy), 64'd1);
        chk("rst_r0rdy", 64'(r0_ready), 64'd0);
        chk("rst_r1rdy", 64'(r1_ready), 64'd0);
        reset = 1'b0;

        // init sweep: 31 writes of DEAD to X0..X30
        for (int i = 0; i < 31; i++) begin
            step();
            chk("init_we3", 64'(we3), 64'd1);
            chk("init_wa3", 64'(wa3), 64'(i));
            chk("init_wd3", wd3, IV);
            chk("init_busy", 64'(init_busy), (i == 30) ? 64'd0 : 64'd1);
        end
        step();
        chk("post_init_we3", 64'(we3), 64'd0);
        chk("post_init_busy", 64'(init_busy), 64'd0);

        // r0 only: X5 = 1234
        r0_valid = 1'b1;
        r0_addr  = 5'd5;
        r0_data  = 64'h1234;
        #1;
        chk("r0_ready", 64'(r0_ready), 64'd1);
        chk("r0_only_r1rdy", 64'(r1_ready), 64'd0);
        step();
        r0_valid = 1'b0;
        chk("r0_we3", 64'(we3), 64'd1);
        chk("r0_wa3", 64'(wa3), 64'd5);
        chk("r0_wd3", wd3, 64'h1234);
        step();
        chk("r0_idle_we3", 64'(we3), 64'd0);
        chk("r0_idle_wa3", 64'(wa3), 64'd5);

        // contention: r0,r0,r0,r1 repeating
        r0_valid = 1'b1;
        r0_addr  = 5'd1;
        r0_data  = 64'h100;
        r1_valid = 1'b1;
        r1_addr  = 5'd2;
        r1_data  = 64'h200;
        seq8 = 8'b1000_1000;
        for (int k = 0; k < 8; k++) begin
            g = seq8[k];
            #1;
            chk("cont_r0rdy", 64'(r0_ready), 64'(!g));
            chk("cont_r1rdy", 64'(r1_ready), 64'(g));
            step();
            chk("cont_wa3", 64'(wa3), g ? 64'd2 : 64'd1);
            chk("cont_wd3", wd3, g ? 64'h200 : 64'h100);
            chk("cont_we3", 64'(we3), 64'd1);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        chk("cont_idle_we3", 64'(we3), 64'd0);

        // XZR write from r1, then a real write to X2
        r1_valid = 1'b1;
        r1_addr  = 5'd31;
        r1_data  = 64'hFF;
        #1;
        chk("xzr_r1rdy", 64'(r1_ready), 64'd1);
        step();
        chk("xzr_we3", 64'(we3), 64'd0);
        chk("xzr_wa3", 64'(wa3), 64'd31);
        chk("xzr_wd3", wd3, 64'hFF);
        r1_addr = 5'd2;
        r1_data = 64'h22;
        #1;
        chk("x2_r1rdy", 64'(r1_ready), 64'd1);
        step();
        r1_valid = 1'b0;
        chk("x2_we3", 64'(we3), 64'd1);
        chk("x2_wa3", 64'(wa3), 64'd2);
        chk("x2_wd3", wd3, 64'h22);

        // fresh reset, then abort the sweep at wa3 = 9
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("mid_wa3_pre", 64'(wa3), 64'd9);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we3", 64'(we3), 64'd0);
        chk("mid_rst_wa3", 64'(wa3), 64'd0);
        chk("mid_rst_wd3", wd3, 64'd0);
        chk("mid_rst_busy", 64'(init_busy), 64'd1);
        step();
        reset = 1'b0;

        // requests pending during the restarted sweep are held off
        r0_valid = 1'b1;
        r0_addr  = 5'd3;
        r0_data  = 64'h33;
        r1_valid = 1'b1;
        r1_addr  = 5'd4;
        r1_data  = 64'h44;
        for (int i = 0; i < 31; i++) begin
            step();
            chk("sw2_we3", 64'(we3), 64'd1);
            chk("sw2_wa3", 64'(wa3), 64'(i));
            chk("sw2_wd3", wd3, IV);
            if (i < 30) begin
                chk("sw2_r0rdy", 64'(r0_ready), 64'd0);
                chk("sw2_r1rdy", 64'(r1_ready), 64'd0);
            end
        end

        // first RUN cycle grants r0; r1 forced after three r0 wins
        seq4 = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            g = seq4[k];
            chk("run1_r0rdy", 64'(r0_ready), 64'(!g));
            chk("run1_r1rdy", 64'(r1_ready), 64'(g));
            step();
            chk("run1_wa3", 64'(wa3), g ? 64'd4 : 64'd3);
            chk("run1_wd3", wd3, g ? 64'h44 : 64'h33);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        chk("end_we3", 64'(we3), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 32x64 register bank and shares it between two requesters.
- Requester 0 is the pipeline writeback stage and has priority. Requester 1 is the secondary writer (load-return/debug) and has starvation protection.
- After reset, an init sequencer first walks X0..X30 with a programmable value.
- Writes to X31 (XZR) are accepted and discarded.

Parameters:
- INIT_EN, 1, 1 = run the init sweep after reset; 0 = go straight to RUN.
- INIT_VALUE, 64'd0, data written to X0..X30 during the init sweep.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations by r1 before r1 is forced through. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_valid  in  1  writeback requests a write.
- r0_ready  out  1  r0 request accepted this cycle.
- r0_addr  in  5  destination register for r0.
- r0_data  in  64  write data for r0.
- r1_valid  in  1  secondary requester requests a write.
- r1_ready  out  1  r1 request accepted this cycle.
- r1_addr  in  5  destination register for r1.
- r1_data  in  64  write data for r1.
- init_busy  out  1  high while the init sweep is pending or running.
- we3  out  1  register-bank write enable (registered).
- wa3  out  5  register-bank write address (registered).
- wd3  out  64  register-bank write data (registered).

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- While reset is high:
  - state = INIT if INIT_EN, else RUN.
  - init_cnt = 0, starve_cnt = 0.
  - we3 = 0, wa3 = 0, wd3 = 0.
  - init_busy = INIT_EN.
  - r0_ready = r1_ready = 0.
- States:
  - INIT: r0_ready = r1_ready = 0 and init_busy = 1. Each edge loads we3 = 1, wa3 = init_cnt, wd3 = INIT_VALUE, then increments init_cnt. The edge that loads wa3 = 30 also moves the state to RUN. init_busy drops in the first RUN cycle. Result: 31 consecutive write cycles, addresses 0..30; X31 is never written.
  - RUN: normal arbitration, as defined below.
- Fire: rN_fire = rN_valid & rN_ready.
- Ready outputs are combinational; in RUN:
  - force1 = (starve_cnt == STARVE_LIMIT) & r1_valid.
  - r0_ready = ~force1.
  - r1_ready = force1 | ~r0_valid.
  - At most one of r0_fire and r1_fire is high in any cycle.
- Output register, RUN, at each edge:
  - On r0_fire: wa3 <= r0_addr, wd3 <= r0_data, we3 <= (r0_addr != 31).
  - Else on r1_fire: wa3 <= r1_addr, wd3 <= r1_data, we3 <= (r1_addr != 31).
  - Else: we3 <= 0, and wa3/wd3 hold their values.
- Latency: accepted at edge N, driven on the port during cycle N..N+1, committed by the bank at edge N+1. The bank's same-cycle bypass makes the data readable during that cycle.
- starve_cnt, RUN:
  - Cleared on r1_fire or when r1_valid = 0.
  - Otherwise incremented when r0_fire occurs while r1 is waiting, saturating at STARVE_LIMIT.
  - Effect: after STARVE_LIMIT consecutive r0 wins, r1 wins the next cycle and r0 sees ready = 0 for that cycle.
- Requester protocol:
  - valid/addr/data must stay stable until ready.
  - If a requester withdraws valid before ready, nothing is written and no error is flagged.
- XZR: a request to address 31 completes the handshake normally. It updates wa3/wd3 but keeps we3 = 0 and counts as a fire for starvation accounting.
- Reset mid-operation (during INIT or RUN): all state and outputs clear immediately. Any in-flight accepted write is dropped. If INIT_EN, the sweep restarts from X0 after release.
- Requests that arrive during INIT are held off (ready = 0) and are accepted in the first RUN cycle.

Test Plan:
- INIT_EN=1, INIT_VALUE=64'hDEAD: release reset, no requests -> we3=1 for exactly 31 cycles with wa3=0..30 and wd3=64'hDEAD; init_busy falls on the next cycle; X31 never addressed.
- RUN, r0 only: r0 writes X5=64'h1234 -> r0_ready=1 the same cycle; next cycle we3=1, wa3=5, wd3=64'h1234; the cycle after that we3=0.
- Contention, STARVE_LIMIT=3: r0_valid and r1_valid held high continuously with distinct addresses -> grant order r0,r0,r0,r1,r0,r0,r0,r1; r0_ready low exactly on the r1 cycles.
- XZR: r1 writes addr 31 data 64'hFF with r0 idle -> r1_ready=1, next cycle we3=0, wa3=31; a following r1 write to X2 is driven with we3=1.
- Reset asserted at INIT cycle 10 (wa3=9) -> outputs go to 0 asynchronously; after release the sweep restarts at wa3=0 and runs a full 31 cycles.
- r0 and r1 both valid during INIT -> both readys stay 0 until RUN; in the first RUN cycle r0 is granted and r1's starve_cnt becomes 1.
